// File: rtl/serial_deframer.sv
// Serial frame receiver: hunts for a sync word, reads a length byte, streams the payload
// through a small first-word-fall-through FIFO and checks a trailing XOR checksum.
module serial_deframer #(
    parameter logic [7:0]  SYNC_WORD  = 8'hA5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_en,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

    // The FIFO pointers wrap naturally only for power-of-two depths.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("serial_deframer: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {StHunt, StLen, StData, StChk} state_e;

    state_e      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  hunt_cnt_q, hunt_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;

    logic [7:0]  byte_w;
    logic        byte_done;
    logic        push;
    logic        push_last;

    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] count_q;
    logic        full;
    logic        pop;
    logic        push_ok;

    // The byte as it will look once the current bit is shifted in.
    assign byte_w    = {sr_q[6:0], din};
    assign byte_done = din_en && (bit_cnt_q == 3'd7);

    // Next-state logic for the framing FSM, shift register and counters.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        hunt_cnt_d  = hunt_cnt_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        chk_d       = chk_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;

        if (din_en) begin
            sr_d      = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                StHunt: begin
                    // Bit counter stays parked so LEN always starts on a byte boundary.
                    bit_cnt_d = 3'd0;
                    if (hunt_cnt_q != 4'd8) begin
                        hunt_cnt_d = hunt_cnt_q + 4'd1;
                    end
                    if (byte_w == SYNC_WORD && hunt_cnt_q >= 4'd7) begin
                        state_d = StLen;
                    end
                end
                StLen: begin
                    if (byte_done) begin
                        len_d = byte_w;
                        if (byte_w == 8'd0) begin
                            frame_err_d = 1'b1;
                            hunt_cnt_d  = 4'd0;
                            state_d     = StHunt;
                        end else begin
                            byte_cnt_d = 8'd0;
                            chk_d      = 8'd0;
                            state_d    = StData;
                        end
                    end
                end
                StData: begin
                    if (byte_done) begin
                        push       = 1'b1;
                        push_last  = (byte_cnt_q == len_q - 8'd1);
                        chk_d      = chk_q ^ byte_w;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (push_last) begin
                            state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    if (byte_done) begin
                        frame_ok_d  = (byte_w == chk_q);
                        frame_err_d = (byte_w != chk_q);
                        hunt_cnt_d  = 4'd0;
                        state_d     = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            sr_q        <= 8'd0;
            bit_cnt_q   <= 3'd0;
            hunt_cnt_q  <= 4'd0;
            len_q       <= 8'd0;
            byte_cnt_q  <= 8'd0;
            chk_q       <= 8'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            hunt_cnt_q  <= hunt_cnt_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            chk_q       <= chk_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign full       = (count_q == FullCnt);
    assign pop        = out_valid && out_ready;
    assign push_ok    = push && (!full || pop);
    assign overflow_d = overflow_q || (push && full && !pop);

    // FIFO storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= {push_last, byte_w};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Output decode; the head is forced to zero while the FIFO is empty.
    always_comb begin
        out_valid = (count_q != '0);
        out_data  = 8'd0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data = mem_q[rptr_q][7:0];
            out_last = mem_q[rptr_q][8];
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StHunt);

    // The two frame status pulses are mutually exclusive.
    a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(frame_ok && frame_err));

    // Overflow only ever clears through reset.
    a_overflow_sticky: assert property (@(posedge clk) disable iff (rst)
        overflow_q |=> overflow_q);

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer: builds frames, predicts the delivered byte stream
// and status pulses from the frame contents, and checks the DUT cycle by cycle.
module tb_serial_deframer;

    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_ok;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    int err_seen = 0;
    int exp_ok = 0;
    int exp_err = 0;

    logic [8:0] exp_q[$];   // {last, data} still to be delivered
    logic [8:0] recv[$];    // {last, data} delivered in the current test
    logic [7:0] frame_q[$];

    serial_deframer #(
        .SYNC_WORD (8'hA5),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_en   (din_en),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every handshake must deliver the next predicted byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok && frame_err) check("pulse_exclusive", 32'd1, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
                end else begin
                    check("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
                    recv.push_back({out_last, out_data});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Optionally spend an idle cycle first so the task ends just after the consuming edge.
    task automatic send_bit(input logic b, input bit toggle);
        if (toggle) begin
            din_en = 1'b0;
            @(posedge clk);
            #1;
        end
        din    = b;
        din_en = 1'b1;
        @(posedge clk);
        #1;
        din_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit toggle);
        for (int i = 7; i >= 0; i--) send_bit(v[i], toggle);
    endtask

    // Sends frame_q and predicts its payload delivery and final status pulse.
    task automatic send_frame(input bit toggle);
        int         len;
        int         cap;
        logic [7:0] x;
        bit         good;
        len = int'(frame_q[1]);
        x   = 8'd0;
        for (int i = 0; i < len; i++) x ^= frame_q[2 + i];
        good = (len != 0) && (x == frame_q[2 + len]);
        // With the consumer stalled only the free FIFO slots can be filled.
        cap = out_ready ? len : FIFO_DEPTH - exp_q.size();
        for (int i = 0; i < len; i++)
            if (i < cap) exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, frame_q[2 + i]});
        if (good) exp_ok++; else exp_err++;
        send_byte(frame_q[0], toggle);
        check("busy_after_sync", {31'd0, busy}, 32'd1);
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], toggle);
        check("frame_ok_pulse", {31'd0, frame_ok}, {31'd0, good});
        check("frame_err_pulse", {31'd0, frame_err}, {31'd0, !good});
        check("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_done", exp_q.size(), 32'd0);
        check("ok_count", ok_seen, exp_ok);
        check("err_count", err_seen, exp_err);
    endtask

    initial begin
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {28'd0, frame_ok, frame_err, overflow, out_last}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Good two-byte frame.
        recv.delete();
        frame_q = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFF};
        send_frame(1'b0);
        drain();
        check("t1_count", recv.size(), 32'd2);
        if (recv.size() == 2) begin
            check("t1_b0", {23'd0, recv[0]}, 32'h03C);
            check("t1_b1", {23'd0, recv[1]}, 32'h1C3);
        end
        check("t1_ok_total", ok_seen, 32'd1);

        // Bad checksum.
        recv.delete();
        frame_q = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'h00};
        send_frame(1'b0);
        drain();
        check("t2_count", recv.size(), 32'd2);
        check("t2_err_total", err_seen, 32'd1);
        check("t2_ok_total", ok_seen, 32'd1);

        // Zero length aborts right after LEN, then a normal frame.
        recv.delete();
        frame_q = '{8'hA5, 8'h00};
        send_frame(1'b0);
        frame_q = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
        send_frame(1'b0);
        drain();
        check("t3_count", recv.size(), 32'd1);
        if (recv.size() == 1) check("t3_b0", {23'd0, recv[0]}, 32'h15A);
        check("t3_err_total", err_seen, 32'd2);

        // Noise before sync, din_en toggling; payload equal to sync must not resync.
        recv.delete();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        check("t4_busy_noise", {31'd0, busy}, 32'd0);
        frame_q = '{8'hA5, 8'h01, 8'hA5, 8'hA5};
        send_frame(1'b1);
        drain();
        check("t4_count", recv.size(), 32'd1);
        if (recv.size() == 1) check("t4_b0", {23'd0, recv[0]}, 32'h1A5);
        check("t4_ok_total", ok_seen, 32'd3);

        // Stalled consumer: FIFO fills, later bytes are dropped, frame still checks good.
        recv.delete();
        out_ready = 1'b0;
        frame_q = '{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_frame(1'b0);
        check("t5_overflow", {31'd0, overflow}, 32'd1);
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        check("t5_head", {24'd0, out_data}, 32'h01);
        out_ready = 1'b1;
        drain();
        check("t5_count", recv.size(), 32'd4);
        if (recv.size() == 4) check("t5_b3", {23'd0, recv[3]}, 32'h004);
        check("t5_overflow_held", {31'd0, overflow}, 32'd1);
        check("t5_ok_total", ok_seen, 32'd4);

        // Reset in the middle of DATA with two bytes buffered.
        recv.delete();
        out_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        check("t6_valid_mid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_q = '{8'hA5, 8'h01, 8'h7E, 8'h7E};
        send_frame(1'b0);
        drain();
        check("t6_count", recv.size(), 32'd1);
        if (recv.size() == 1) check("t6_b0", {23'd0, recv[0]}, 32'h17E);
        check("t6_ok_total", ok_seen, 32'd5);
        check("t6_err_total", err_seen, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
